// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared width helper, limits and tag type for the multiplier arbiter
package mult_arb_pkg;
  localparam int MAX_REQ = 16;
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
  typedef struct packed {
    logic vld;
    logic [MAX_REQ-1:0] id;
  } tag_t;
endpackage

// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: request/response bundle between requesters (master) and the arbiter (slave)
interface mult_arbiter_if
  import mult_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32
);
  localparam int ID_W = id_width(N_REQ);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ*A_WIDTH-1:0] req_a;
  logic [N_REQ*B_WIDTH-1:0] req_b;
  logic resp_valid;
  logic [ID_W-1:0] resp_id;
  logic signed [A_WIDTH+B_WIDTH-1:0] resp_y;
  logic busy;
  modport master (
    output req_valid, req_a, req_b,
    input req_ready, resp_valid, resp_id, resp_y, busy
  );
  modport slave (
    input req_valid, req_a, req_b,
    output req_ready, resp_valid, resp_id, resp_y, busy
  );
endinterface

// File: rtl/multiplier_wrapper.sv
// multiplier_wrapper: signed full-precision multiply; USE_IP=1 stands in for the vendor IP with MULT_LATENCY register stages
module multiplier_wrapper #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32,
  parameter int USE_IP = 0,
  parameter int MULT_LATENCY = 0
) (
  input logic clk,
  input logic signed [A_WIDTH-1:0] a,
  input logic signed [B_WIDTH-1:0] b,
  output logic signed [A_WIDTH+B_WIDTH-1:0] y
);
  localparam int Y_W = A_WIDTH + B_WIDTH;
  logic signed [Y_W-1:0] p;
  assign p = $signed(Y_W'(a)) * $signed(Y_W'(b));
  if (USE_IP == 0 || MULT_LATENCY == 0) begin : g_comb
    logic unused_clk;
    assign unused_clk = clk;
    assign y = p;
  end else begin : g_ip
    logic signed [Y_W-1:0] st [MULT_LATENCY];
    // product pipeline matching the IP's internal register stages
    always_ff @(posedge clk) begin
      st[0] <= p;
      for (int k = 1; k < MULT_LATENCY; k++) st[k] <= st[k-1];
    end
    assign y = st[MULT_LATENCY-1];
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant starting after ptr; MULT_ARB_PRIO0_EN gives requester 0 strict priority
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int ID_W = id_width(N_REQ)
) (
  input logic [N_REQ-1:0] req,
  input logic [ID_W-1:0] ptr,
  output logic [N_REQ-1:0] grant
);
  logic [ID_W-1:0] idx;
  // scan farthest-first so the nearest valid requester after ptr overwrites and wins
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(ptr) + k) % N_REQ);
      grant = req[idx] ? (N_REQ'(1) << idx) : grant;
    end
`ifdef MULT_ARB_PRIO0_EN
    grant = req[0] ? N_REQ'(1) : grant;
`endif
  end
endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one multiplier among N_REQ requesters, tagging each product with its requester id (macro MULT_ARB_PRIO0_EN: requester 0 strict priority)
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32,
  parameter int USE_IP = 0,
  parameter int MULT_LATENCY = 0
) (
  input logic clk,
  input logic rst,
  mult_arbiter_if.slave bus
);
  localparam int ID_W = id_width(N_REQ);
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0] ptr, gnt_id, issue_id;
  logic issue_vld, ptr_upd, pipe_busy;
  logic signed [A_WIDTH-1:0] op_a;
  logic signed [B_WIDTH-1:0] op_b;
  tag_t head, tail;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (.req(bus.req_valid), .ptr, .grant);

  assign bus.req_ready = rst ? '0 : grant;

`ifdef MULT_ARB_PRIO0_EN
  assign ptr_upd = |grant[N_REQ-1:1];
`else
  assign ptr_upd = |grant;
`endif

  // one-hot grant to requester index
  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < N_REQ; i++) gnt_id = grant[i] ? ID_W'(i) : gnt_id;
  end

  // issue stage: latch the winner's operands and advance the round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= ID_W'(N_REQ - 1);
      issue_vld <= 1'b0;
      issue_id <= '0;
      op_a <= '0;
      op_b <= '0;
    end else begin
      issue_vld <= |grant;
      if (ptr_upd) ptr <= gnt_id;
      if (|grant) begin
        issue_id <= gnt_id;
        op_a <= bus.req_a[gnt_id*A_WIDTH +: A_WIDTH];
        op_b <= bus.req_b[gnt_id*B_WIDTH +: B_WIDTH];
      end
    end
  end

  multiplier_wrapper #(
    .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .USE_IP(USE_IP), .MULT_LATENCY(MULT_LATENCY)
  ) u_mult (.clk, .a(op_a), .b(op_b), .y(bus.resp_y));

  assign head = '{vld: issue_vld, id: MAX_REQ'(issue_id)};

  if (MULT_LATENCY == 0) begin : g_direct
    assign tail = head;
    assign pipe_busy = 1'b0;
  end else begin : g_pipe
    tag_t sr [MULT_LATENCY];
    // tag shift register tracking products inside the multiplier; reset drops them
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < MULT_LATENCY; k++) sr[k] <= '0;
      end else begin
        sr[0] <= head;
        for (int k = 1; k < MULT_LATENCY; k++) sr[k] <= sr[k-1];
      end
    end
    // any valid tag in the pipeline means a product is in flight
    always_comb begin
      pipe_busy = 1'b0;
      for (int k = 0; k < MULT_LATENCY; k++) pipe_busy = pipe_busy | sr[k].vld;
    end
    assign tail = sr[MULT_LATENCY-1];
  end

  assign bus.resp_valid = tail.vld;
  assign bus.resp_id = ID_W'(tail.id);
  assign bus.busy = issue_vld | pipe_busy;
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed checks of arbitration order, products, latency and reset for mult_arbiter
module tb_mult_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  mult_arbiter_if #(.N_REQ(4), .A_WIDTH(32), .B_WIDTH(32)) bus0 ();
  mult_arbiter_if #(.N_REQ(4), .A_WIDTH(32), .B_WIDTH(32)) bus3 ();

  mult_arbiter #(.N_REQ(4), .A_WIDTH(32), .B_WIDTH(32), .USE_IP(0), .MULT_LATENCY(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mult_arbiter #(.N_REQ(4), .A_WIDTH(32), .B_WIDTH(32), .USE_IP(1), .MULT_LATENCY(3))
    dut3 (.clk(clk), .rst(rst), .bus(bus3));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus0.req_valid = '0;
    bus3.req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus0.req_valid = '1;
    bus3.req_valid = '1;
    tick();
    tick();
    #1;
    total++;
    if (bus0.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready0 got=%b want=0000", bus0.req_ready); end
    total++;
    if (bus3.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready3 got=%b want=0000", bus3.req_ready); end
    total++;
    if ({bus0.resp_valid, bus0.busy, bus0.resp_id} !== 4'b0000) begin
      bad++; $display("FAIL reset_outs0 got vld=%b busy=%b id=%0d want 0/0/0", bus0.resp_valid, bus0.busy, bus0.resp_id);
    end
    total++;
    if (bus0.resp_y !== 64'sd0) begin bad++; $display("FAIL reset_y0 got=%0d want=0", bus0.resp_y); end
    total++;
    if ({bus3.resp_valid, bus3.busy, bus3.resp_id} !== 4'b0000) begin
      bad++; $display("FAIL reset_outs3 got vld=%b busy=%b id=%0d want 0/0/0", bus3.resp_valid, bus3.busy, bus3.resp_id);
    end
    bus0.req_valid = '0;
    bus3.req_valid = '0;
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if ({bus0.resp_valid, bus0.busy, bus0.req_ready} !== 6'b0) begin
        bad++; $display("FAIL idle cycle %0d got vld=%b busy=%b ready=%b want all 0", c, bus0.resp_valid, bus0.busy, bus0.req_ready);
      end
    end
  endtask

  task automatic test_single();
    logic signed [63:0] ey;
    ey = -21;
    bus0.req_a[64 +: 32] = 32'sd7;
    bus0.req_b[64 +: 32] = -32'sd3;
    bus0.req_valid = 4'b0100;
    #1;
    total++;
    if (bus0.req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b want=0100", bus0.req_ready); end
    tick();
    bus0.req_valid = '0;
    total++;
    if (bus0.resp_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", bus0.resp_valid); end
    total++;
    if (bus0.resp_id !== 2'd2) begin bad++; $display("FAIL single_id got=%0d want=2", bus0.resp_id); end
    total++;
    if (bus0.resp_y !== ey) begin bad++; $display("FAIL single_y got=%0d want=%0d", bus0.resp_y, ey); end
    total++;
    if (bus0.busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", bus0.busy); end
    tick();
    total++;
    if ({bus0.resp_valid, bus0.busy} !== 2'b00) begin
      bad++; $display("FAIL single_drain got vld=%b busy=%b want 0/0", bus0.resp_valid, bus0.busy);
    end
  endtask

  task automatic test_round_robin();
    logic signed [63:0] ey;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus0.req_a[i*32 +: 32] = 32'(i + 1);
      bus0.req_b[i*32 +: 32] = 32'sd10;
    end
    bus0.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      total++;
      if (bus0.req_ready !== 4'(1 << (k % 4))) begin
        bad++; $display("FAIL rr_ready step %0d got=%b want=%b", k, bus0.req_ready, 4'(1 << (k % 4)));
      end
      tick();
      if (k == 7) bus0.req_valid = '0;
      ey = 64'(10 * (k % 4 + 1));
      total++;
      if ({bus0.resp_valid, bus0.resp_id} !== {1'b1, 2'(k % 4)}) begin
        bad++; $display("FAIL rr_resp step %0d got vld=%b id=%0d want 1/%0d", k, bus0.resp_valid, bus0.resp_id, k % 4);
      end
      total++;
      if (bus0.resp_y !== ey) begin bad++; $display("FAIL rr_y step %0d got=%0d want=%0d", k, bus0.resp_y, ey); end
    end
    tick();
    total++;
    if ({bus0.resp_valid, bus0.busy} !== 2'b00) begin
      bad++; $display("FAIL rr_drain got vld=%b busy=%b want 0/0", bus0.resp_valid, bus0.busy);
    end
  endtask

  task automatic test_skip();
    logic [3:0] vin [5];
    logic [3:0] exp [5];
    logic [1:0] eid [5];
    vin = '{4'b1010, 4'b1010, 4'b1010, 4'b0100, 4'b1010};
    exp = '{4'b0010, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
    eid = '{2'd1, 2'd3, 2'd1, 2'd2, 2'd3};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      bus0.req_valid = vin[k];
      #1;
      total++;
      if (bus0.req_ready !== exp[k]) begin bad++; $display("FAIL skip_ready step %0d got=%b want=%b", k, bus0.req_ready, exp[k]); end
      tick();
      total++;
      if ({bus0.resp_valid, bus0.resp_id} !== {1'b1, eid[k]}) begin
        bad++; $display("FAIL skip_resp step %0d got vld=%b id=%0d want 1/%0d", k, bus0.resp_valid, bus0.resp_id, eid[k]);
      end
    end
    bus0.req_valid = '0;
    tick();
  endtask

  task automatic test_back_to_back_extremes();
    logic signed [63:0] ey;
    do_reset();
    bus0.req_a[96 +: 32] = 32'h8000_0000;
    bus0.req_b[96 +: 32] = 32'h8000_0000;
    bus0.req_valid = 4'b1000;
    #1;
    total++;
    if (bus0.req_ready !== 4'b1000) begin bad++; $display("FAIL ext_ready0 got=%b want=1000", bus0.req_ready); end
    tick();
    bus0.req_a[96 +: 32] = 32'h7FFF_FFFF;
    #1;
    total++;
    if (bus0.req_ready !== 4'b1000) begin bad++; $display("FAIL ext_ready1 got=%b want=1000", bus0.req_ready); end
    ey = 64'sh4000_0000_0000_0000;
    total++;
    if ({bus0.resp_valid, bus0.resp_id} !== 3'b111) begin
      bad++; $display("FAIL ext_resp0 got vld=%b id=%0d want 1/3", bus0.resp_valid, bus0.resp_id);
    end
    total++;
    if (bus0.resp_y !== ey) begin bad++; $display("FAIL ext_min_min got=%h want=%h", bus0.resp_y, ey); end
    tick();
    bus0.req_valid = '0;
    ey = 64'shC000_0000_8000_0000;
    total++;
    if (bus0.resp_valid !== 1'b1) begin bad++; $display("FAIL ext_resp1 got vld=%b want 1", bus0.resp_valid); end
    total++;
    if (bus0.resp_y !== ey) begin bad++; $display("FAIL ext_max_min got=%h want=%h", bus0.resp_y, ey); end
    tick();
  endtask

  task automatic test_midflight_reset();
    logic signed [63:0] ey;
    ey = 6;
    do_reset();
    bus3.req_a[32 +: 32] = 32'sd5;
    bus3.req_b[32 +: 32] = 32'sd6;
    bus3.req_valid = 4'b0010;
    #1;
    total++;
    if (bus3.req_ready !== 4'b0010) begin bad++; $display("FAIL mid_ready got=%b want=0010", bus3.req_ready); end
    tick();
    bus3.req_valid = '0;
    total++;
    if (bus3.busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", bus3.busy); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({bus3.resp_valid, bus3.busy} !== 2'b00) begin
      bad++; $display("FAIL mid_after_rst got vld=%b busy=%b want 0/0", bus3.resp_valid, bus3.busy);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if ({bus3.resp_valid, bus3.busy} !== 2'b00) begin
        bad++; $display("FAIL mid_dropped cycle %0d got vld=%b busy=%b want 0/0", c, bus3.resp_valid, bus3.busy);
      end
    end
    bus3.req_a[0 +: 32] = 32'sd2;
    bus3.req_b[0 +: 32] = 32'sd3;
    bus3.req_valid = 4'b0011;
    #1;
    total++;
    if (bus3.req_ready !== 4'b0001) begin bad++; $display("FAIL mid_next_grant got=%b want=0001", bus3.req_ready); end
    tick();
    bus3.req_valid = '0;
    for (int j = 1; j <= 3; j++) begin
      total++;
      if ({bus3.resp_valid, bus3.busy} !== 2'b01) begin
        bad++; $display("FAIL lat3 cycle N+%0d got vld=%b busy=%b want 0/1", j, bus3.resp_valid, bus3.busy);
      end
      tick();
    end
    total++;
    if ({bus3.resp_valid, bus3.resp_id} !== 3'b100) begin
      bad++; $display("FAIL lat3_resp got vld=%b id=%0d want 1/0", bus3.resp_valid, bus3.resp_id);
    end
    total++;
    if (bus3.resp_y !== ey) begin bad++; $display("FAIL lat3_y got=%0d want=%0d", bus3.resp_y, ey); end
    tick();
    total++;
    if ({bus3.resp_valid, bus3.busy} !== 2'b00) begin
      bad++; $display("FAIL lat3_drain got vld=%b busy=%b want 0/0", bus3.resp_valid, bus3.busy);
    end
  endtask

  task automatic test_prio0();
    logic [3:0] vin [4];
    logic [3:0] exp [4];
    vin = '{4'b0011, 4'b0011, 4'b0011, 4'b0010};
`ifdef MULT_ARB_PRIO0_EN
    exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
`else
    exp = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus0.req_valid = vin[k];
      #1;
      total++;
      if (bus0.req_ready !== exp[k]) begin bad++; $display("FAIL prio_ready step %0d got=%b want=%b", k, bus0.req_ready, exp[k]); end
      tick();
    end
    bus0.req_valid = '0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.req_valid = '0;
    bus0.req_a = '0;
    bus0.req_b = '0;
    bus3.req_valid = '0;
    bus3.req_a = '0;
    bus3.req_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_skip();
    test_back_to_back_extremes();
    test_midflight_reset();
    test_prio0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one multiplier_wrapper instance between N_REQ requesters, e.g. the biquad sections of the IIR core.
- Arbitrates with a round-robin policy, at most one grant per cycle. Each request has a valid/ready handshake; operands are registered into the multiplier.
- Each product is returned with the ID of the requester that issued it.
- Fully pipelined: back-to-back grants are sustained, so throughput is 1 product per cycle.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- A_WIDTH, 32, operand A width, signed.
- B_WIDTH, 32, operand B width, signed.
- USE_IP, 0, passed to multiplier_wrapper; 1 selects the vendor multiplier IP.
- MULT_LATENCY, 0, register stages inside the multiplier. Must be 0 when USE_IP=0 and must match the IP configuration when USE_IP=1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester grant/accept.
- req_a  input  N_REQ*A_WIDTH  packed signed operands A; requester i occupies bits [i*A_WIDTH +: A_WIDTH].
- req_b  input  N_REQ*B_WIDTH  packed signed operands B, same packing.
- resp_valid  output  1  product valid; there is no backpressure.
- resp_id  output  ID_W  requester index of the product, ID_W = max(1, $clog2(N_REQ)).
- resp_y  output  A_WIDTH+B_WIDTH  signed full-precision product.
- busy  output  1  high while any product is in flight.

Behaviour:
- Handshake:
  - A transfer on requester i occurs in a cycle where req_valid[i] && req_ready[i].
  - req_ready is combinational from req_valid and the pointer.
  - req_ready is one-hot or zero, and never asserted without the matching req_valid.
  - A requester holds req_a/req_b stable while valid && !ready.
  - A requester may deassert valid without having been granted.
- Arbitration state:
  - ptr holds the index of the last granted requester.
  - The search begins at ptr+1 modulo N_REQ, wrapping from N_REQ-1 to 0.
  - The first valid requester found is granted, and ptr updates to it on the same clock edge.
  - If no requester is valid, ptr holds.
- Issue stage:
  - On a grant, the selected operands are registered into op_a/op_b, with issue_vld=1 and issue_id=granted index.
  - With no grant, issue_vld=0 and the operand registers hold.
  - op_a/op_b feed multiplier_wrapper directly.
- Tag pipeline:
  - A shift register of depth MULT_LATENCY carries {vld, id} alongside the multiplier.
  - resp_valid/resp_id are the pipeline tail; resp_y is the multiplier output y.
- Latency: grant cycle N produces resp_valid in cycle N+1+MULT_LATENCY.
- resp_y is only meaningful when resp_valid=1.
- Arithmetic: signed A_WIDTH x B_WIDTH, full A_WIDTH+B_WIDTH result, no rounding or saturation.
- Extreme values: -2^(A_WIDTH-1) x -2^(B_WIDTH-1) yields +2^(A_WIDTH+B_WIDTH-2) exactly.
- busy = OR of issue_vld and all pipeline valid bits.
- Reset, including mid-operation:
  - Clears issue_vld and all pipeline valid bits; in-flight products are dropped, with no resp_valid for them.
  - ptr resets to N_REQ-1, so requester 0 wins first.
  - req_ready=0 while rst=1.
  - Other outputs after reset: resp_valid=0, resp_id=0, busy=0.
  - The operand registers reset to 0, so resp_y settles to 0.
- Simultaneous requests from all requesters: grants rotate 0,1,2,3,0,… with one grant per cycle and no starvation.
- Bound: worst-case wait is N_REQ-1 cycles.

Optional Feature:
- Macro: MULT_ARB_PRIO0_EN.
- Defined:
  - Requester 0 has strict priority; if req_valid[0]=1 it is granted regardless of ptr.
  - ptr does not update on a requester-0 grant.
  - Requesters 1..N_REQ-1 round-robin among themselves when requester 0 is idle.
  - Intended for the IIR feedback path.
  - Starvation of 1..N_REQ-1 is permitted while requester 0 is continuously valid.
- Undefined: pure round-robin as above.
- Ports and latency are identical in both builds.

Decomposition:
- Package mult_arb_pkg holds:
  - function id_width(n) returning max(1, $clog2(n));
  - localparam MAX_REQ=16;
  - typedef tag_t, the {vld, id} struct used by the tag pipeline (id at MAX_REQ width, truncated at use).
- Sub-module rr_arbiter(N_REQ): combinational one-hot grant from req vector and ptr, with the MULT_ARB_PRIO0_EN override inside it.
  - The ptr register stays in mult_arbiter.
- multiplier_wrapper is instantiated unchanged.

Test Plan:
- Reset then idle: no req_valid for 10 cycles -> resp_valid=0, busy=0, req_ready=0 throughout.
- Single request: requester 2 sends a=7, b=-3 (MULT_LATENCY=0) -> req_ready[2]=1 in the same cycle; one cycle later resp_valid=1, resp_id=2, resp_y=-21.
- All four requesters valid continuously for 8 cycles, a=i+1, b=10 -> grant order 0,1,2,3,0,1,2,3; resp_y sequence 10,20,30,40,… with matching resp_id.
- Extremes, A_WIDTH=B_WIDTH=32: a=b=-2^31 -> resp_y=+2^62; a=2^31-1, b=-2^31 -> resp_y=-2^62+2^31.
- Reset mid-flight, MULT_LATENCY=3: grant in cycle 0, rst=1 in cycle 2 -> no resp_valid for that product; busy=0 after reset; the next grant goes to requester 0.
- MULT_ARB_PRIO0_EN build: req 0 and req 1 both valid for 3 cycles -> req 0 granted every cycle; req 0 drops -> req 1 granted next cycle.
